// File: rtl/core_if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface core_if_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/core_if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches and buffers the
// returned words with their PCs for decode; redirects flush the buffer and drop stale responses.
module core_if_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [XLEN-1:0]   i_redirect_pc,
    core_if_stage_if.master   io_imem,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_instr,
    output logic [XLEN-1:0]   o_pc
);

    localparam int unsigned     PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned     CW        = PW + 1;
    localparam logic [CW:0]     DEPTH_C   = (CW+1)'(BUF_DEPTH);
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   r_fifo_count;
    logic [PW-1:0]   r_ifq_wp;
    logic [PW-1:0]   r_ifq_rp;
    logic [PW-1:0]   r_fifo_wp;
    logic [PW-1:0]   r_fifo_rp;
    logic [XLEN-1:0] r_ifq_pc     [BUF_DEPTH];
    logic [XLEN-1:0] r_fifo_pc    [BUF_DEPTH];
    logic [XLEN-1:0] r_fifo_instr [BUF_DEPTH];

    logic [CW:0]     w_credit_sum;
    logic            w_req;
    logic            w_fire;
    logic            w_resp;
    logic            w_discard;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic [CW-1:0]   w_out_next;

    // Credit uses registered counts only, so in-flight plus buffered never exceeds the FIFO size.
    assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
    assign w_req        = i_rst_n && !i_redirect && (w_credit_sum < DEPTH_C);
    assign w_fire       = w_req && io_imem.gnt;
    assign w_resp       = io_imem.rvalid && (r_outstanding != '0);
    assign w_discard    = w_resp && (r_drop != '0);
    assign w_push       = w_resp && !w_discard && !i_redirect;
    assign w_valid      = (r_fifo_count != '0);
    assign w_pop        = w_valid && !i_stall;
    assign w_out_next   = r_outstanding + CW'(w_fire) - CW'(w_resp);

    assign io_imem.req  = w_req;
    assign io_imem.addr = r_pc;
    assign o_valid      = w_valid;
    assign o_instr      = w_valid ? r_fifo_instr[r_fifo_rp] : NOP_INSTR;
    assign o_pc         = w_valid ? r_fifo_pc[r_fifo_rp]    : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_ifq_wp      <= '0;
            r_ifq_rp      <= '0;
            r_fifo_wp     <= '0;
            r_fifo_rp     <= '0;
            r_fifo_count  <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_fire) begin
                r_ifq_wp <= r_ifq_wp + PW'(1);
            end
            if (w_resp) begin
                r_ifq_rp <= r_ifq_rp + PW'(1);
            end
            // Every response still owed after this cycle belongs to the abandoned path.
            if (i_redirect) begin
                r_pc         <= i_redirect_pc & ~XLEN'(3);
                r_drop       <= w_out_next;
                r_fifo_wp    <= '0;
                r_fifo_rp    <= '0;
                r_fifo_count <= '0;
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (w_discard) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_fifo_wp <= r_fifo_wp + PW'(1);
                end
                if (w_pop) begin
                    r_fifo_rp <= r_fifo_rp + PW'(1);
                end
                r_fifo_count <= r_fifo_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_fire) begin
            r_ifq_pc[r_ifq_wp] <= r_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_fifo_wp]    <= r_ifq_pc[r_ifq_rp];
            r_fifo_instr[r_fifo_wp] <= io_imem.rdata;
        end
    end

    // A response with nothing in flight is an imem protocol violation and is ignored.
    a_no_orphan_rvalid: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(io_imem.rvalid && (r_outstanding == '0))
    );

endmodule
